// File: rtl/assoc_cache_ctrl_if.sv
// CPU-side command/response and next-level request bundle
// for the set-associative cache controller.
interface assoc_cache_ctrl_if #(
  parameter int ADDR_W     = 32,
  parameter int LINE_BYTES = 64
);
  localparam int OFF_W = $clog2(LINE_BYTES);

  logic                    req_valid;
  logic                    req_ready;
  logic [1:0]              req_cmd;
  logic [ADDR_W-1:0]       req_addr;
  logic                    rsp_valid;
  logic                    rsp_hit;
  logic                    mem_valid;
  logic                    mem_ready;
  logic                    mem_we;
  logic [ADDR_W-OFF_W-1:0] mem_addr;

  modport master (
    output req_valid, req_cmd, req_addr, mem_ready,
    input  req_ready, rsp_valid, rsp_hit,
    input  mem_valid, mem_we, mem_addr
  );

  modport slave (
    input  req_valid, req_cmd, req_addr, mem_ready,
    output req_ready, rsp_valid, rsp_hit,
    output mem_valid, mem_we, mem_addr
  );
endinterface

// File: rtl/assoc_cache_ctrl.sv
// N-way set-associative cache controller: tag/valid/dirty/LRU
// state, write-back/write-allocate, saturating statistics.
module assoc_cache_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int SETS       = 16384,
  parameter int WAYS       = 4,
  parameter int LINE_BYTES = 64,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  assoc_cache_ctrl_if.slave bus,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [CNT_W-1:0] read_cnt,
  output logic [CNT_W-1:0] write_cnt,
  output logic [CNT_W-1:0] wb_cnt
);
  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int AGE_W = $clog2(WAYS);
  localparam int LA_W  = ADDR_W - OFF_W;

  typedef enum logic [2:0] {
    SWEEP, IDLE, LOOKUP, WB, FILL, RESP
  } state_e;
  typedef enum logic [1:0] {
    C_READ, C_WRITE, C_INV, C_CLEAR
  } cmd_e;

  typedef logic [WAYS-1:0][TAG_W-1:0] tag_row_t;
  typedef logic [WAYS-1:0][AGE_W-1:0] age_row_t;

  tag_row_t        tag_q [SETS];
  logic [WAYS-1:0] valid_q [SETS];
  logic [WAYS-1:0] dirty_q [SETS];
  age_row_t        age_q [SETS];

  state_e           state_q, state_d;
  cmd_e             cmd_q, cmd_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;
  logic [LA_W-1:0]  line_q, line_d;
  logic [AGE_W-1:0] way_q, way_d;
  logic             rhit_q, rhit_d;
  logic             clr_q, clr_d;
  logic [CNT_W-1:0] hit_q, hit_d, miss_q, miss_d;
  logic [CNT_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0] wbc_q, wbc_d;

  logic             row_we;
  logic [IDX_W-1:0] row_idx;
  tag_row_t         tag_d;
  logic [WAYS-1:0]  valid_d, dirty_d;
  age_row_t         age_d;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] ltag;
  tag_row_t         cur_tag;
  logic [WAYS-1:0]  cur_valid, cur_dirty;
  age_row_t         cur_age;
  logic             any_hit, inv_found;
  logic [AGE_W-1:0] hit_way, victim;

  function automatic age_row_t mru(
    input age_row_t a, input logic [AGE_W-1:0] w);
    age_row_t r;
    r = a;
    for (int i = 0; i < WAYS; i++) begin
      if (AGE_W'(i) == w) r[i] = '0;
      else if (a[i] < a[w]) r[i] = a[i] + AGE_W'(1);
    end
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat(
    input logic [CNT_W-1:0] x);
    return (&x) ? x : x + CNT_W'(1);
  endfunction

  assign idx       = line_q[IDX_W-1:0];
  assign ltag      = line_q[LA_W-1:IDX_W];
  assign cur_tag   = tag_q[idx];
  assign cur_valid = valid_q[idx];
  assign cur_dirty = dirty_q[idx];
  assign cur_age   = age_q[idx];

  assign hit_cnt   = hit_q;
  assign miss_cnt  = miss_q;
  assign read_cnt  = rd_q;
  assign write_cnt = wr_q;
  assign wb_cnt    = wbc_q;
  assign bus.rsp_hit = rhit_q;

  // Tag match and victim choice for the registered set.
  always_comb begin
    any_hit   = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    victim    = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!any_hit && cur_valid[w] && cur_tag[w] == ltag) begin
        any_hit = 1'b1;
        hit_way = AGE_W'(w);
      end
      if (!inv_found && !cur_valid[w]) begin
        inv_found = 1'b1;
        victim    = AGE_W'(w);
      end
    end
    if (!inv_found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (cur_age[w] == AGE_W'(WAYS-1)) victim = AGE_W'(w);
      end
    end
  end

  // Controller FSM: next state, row update, bus outputs.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    sweep_d = sweep_q;
    line_d  = line_q;
    way_d   = way_q;
    rhit_d  = rhit_q;
    clr_d   = clr_q;
    hit_d   = hit_q;
    miss_d  = miss_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    wbc_d   = wbc_q;
    row_we  = 1'b0;
    row_idx = idx;
    tag_d   = cur_tag;
    valid_d = cur_valid;
    dirty_d = cur_dirty;
    age_d   = cur_age;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.mem_valid = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    unique case (state_q)
      SWEEP: begin
        row_we  = 1'b1;
        row_idx = sweep_q;
        valid_d = '0;
        dirty_d = '0;
        for (int w = 0; w < WAYS; w++) age_d[w] = AGE_W'(w);
        sweep_d = sweep_q + IDX_W'(1);
        if (sweep_q == IDX_W'(SETS-1)) begin
          state_d = clr_q ? RESP : IDLE;
          clr_d   = 1'b0;
          rhit_d  = 1'b0;
        end
      end
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          cmd_d  = cmd_e'(bus.req_cmd);
          line_d = bus.req_addr[ADDR_W-1:OFF_W];
          if (cmd_e'(bus.req_cmd) == C_CLEAR) begin
            state_d = SWEEP;
            sweep_d = '0;
            clr_d   = 1'b1;
            hit_d   = '0;
            miss_d  = '0;
            rd_d    = '0;
            wr_d    = '0;
            wbc_d   = '0;
          end else begin
            state_d = LOOKUP;
          end
        end
      end
      LOOKUP: begin
        if (cmd_q == C_INV) begin
          rhit_d  = any_hit;
          way_d   = hit_way;
          state_d = RESP;
          if (any_hit && cur_dirty[hit_way]) begin
            state_d = WB;
          end else if (any_hit) begin
            row_we           = 1'b1;
            valid_d[hit_way] = 1'b0;
          end
        end else begin
          if (cmd_q == C_WRITE) wr_d = sat(wr_q);
          else rd_d = sat(rd_q);
          if (any_hit) begin
            hit_d   = sat(hit_q);
            rhit_d  = 1'b1;
            row_we  = 1'b1;
            age_d   = mru(cur_age, hit_way);
            if (cmd_q == C_WRITE) dirty_d[hit_way] = 1'b1;
            state_d = RESP;
          end else begin
            miss_d  = sat(miss_q);
            rhit_d  = 1'b0;
            way_d   = victim;
            state_d = (cur_valid[victim] && cur_dirty[victim])
                      ? WB : FILL;
          end
        end
      end
      WB: begin
        bus.mem_valid = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = {cur_tag[way_q], idx};
        if (bus.mem_ready) begin
          wbc_d = sat(wbc_q);
          if (cmd_q == C_INV) begin
            row_we         = 1'b1;
            valid_d[way_q] = 1'b0;
            dirty_d[way_q] = 1'b0;
            state_d        = RESP;
          end else begin
            state_d = FILL;
          end
        end
      end
      FILL: begin
        bus.mem_valid = 1'b1;
        bus.mem_addr  = line_q;
        if (bus.mem_ready) begin
          row_we         = 1'b1;
          tag_d[way_q]   = ltag;
          valid_d[way_q] = 1'b1;
          dirty_d[way_q] = (cmd_q == C_WRITE);
          age_d          = mru(cur_age, way_q);
          state_d        = RESP;
        end
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = SWEEP;
    endcase
  end

  // Control and statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SWEEP;
      cmd_q   <= C_READ;
      sweep_q <= '0;
      line_q  <= '0;
      way_q   <= '0;
      rhit_q  <= 1'b0;
      clr_q   <= 1'b0;
      hit_q   <= '0;
      miss_q  <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      wbc_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      sweep_q <= sweep_d;
      line_q  <= line_d;
      way_q   <= way_d;
      rhit_q  <= rhit_d;
      clr_q   <= clr_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      wbc_q   <= wbc_d;
    end
  end

  // Per-set state; contents are rebuilt by the sweep after reset.
  always_ff @(posedge clk) begin
    if (row_we) begin
      tag_q[row_idx]   <= tag_d;
      valid_q[row_idx] <= valid_d;
      dirty_q[row_idx] <= dirty_d;
      age_q[row_idx]   <= age_d;
    end
  end
endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// Scoreboard bench for assoc_cache_ctrl with SETS=4, WAYS=4,
// 64-byte lines: directed command sequences.
module tb_assoc_cache_ctrl;
  localparam int ADDR_W = 32;
  localparam int LA_W   = 26;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] hit_cnt, miss_cnt, read_cnt, write_cnt, wb_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  logic            rsp_q [$];
  logic [LA_W:0]   mem_q [$];

  assoc_cache_ctrl_if #(.ADDR_W(ADDR_W), .LINE_BYTES(64)) bus ();

  assoc_cache_ctrl #(
    .ADDR_W(ADDR_W), .SETS(4), .WAYS(4),
    .LINE_BYTES(64), .CNT_W(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
    .read_cnt(read_cnt), .write_cnt(write_cnt),
    .wb_cnt(wb_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  // Monitor: pop expected responses / mem requests as they appear.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rsp_valid) begin
        if (rsp_q.size() == 0) check("rsp_unexpected", 1, 0);
        else check("rsp_hit", bus.rsp_hit, rsp_q.pop_front());
      end
      if (bus.mem_valid && bus.mem_ready) begin
        if (mem_q.size() == 0) check("mem_unexpected", 1, 0);
        else check("mem_req", {bus.mem_we, bus.mem_addr},
                   mem_q.pop_front());
      end
    end
  end

  task automatic exp_mem(input logic we, input logic [LA_W-1:0] a);
    mem_q.push_back({we, a});
  endtask

  task automatic do_cmd(input logic [1:0] c,
                        input logic [31:0] a,
                        input logic exp_hit,
                        input bit chk_lat);
    int n;
    int lat;
    rsp_q.push_back(exp_hit);
    bus.req_cmd   = c;
    bus.req_addr  = a;
    bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.req_ready) begin
      check("accept_timeout", 1, 0);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 300) begin
      @(posedge clk); #1; lat++;
    end
    if (!bus.rsp_valid) check("rsp_timeout", 1, 0);
    else if (chk_lat) check("hit_latency", lat, 2);
    @(posedge clk); #1;
  endtask

  task automatic sweep_wait();
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      check($sformatf("sweep_ready_%0d", i),
            bus.req_ready, (i == 4));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_cmd   = 2'd0;
    bus.req_addr  = '0;
    bus.mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_mem_valid", bus.mem_valid, 0);
    check("rst_counters",
          {hit_cnt, miss_cnt, read_cnt, write_cnt, wb_cnt}, 0);

    // 1: sweep after reset release
    @(negedge clk); rst_n = 1'b1;
    sweep_wait();

    // 2: cold miss then hit
    exp_mem(1'b0, 26'h0);
    do_cmd(2'd0, 32'h000, 1'b0, 0);
    do_cmd(2'd0, 32'h000, 1'b1, 1);
    check("t2_hit",  hit_cnt,  1);
    check("t2_miss", miss_cnt, 1);
    check("t2_read", read_cnt, 2);

    // 3: LRU victim selection
    do_cmd(2'd0, 32'h000, 1'b1, 1);
    exp_mem(1'b0, 26'h4);  do_cmd(2'd0, 32'h100, 1'b0, 0);
    exp_mem(1'b0, 26'h8);  do_cmd(2'd0, 32'h200, 1'b0, 0);
    exp_mem(1'b0, 26'hC);  do_cmd(2'd0, 32'h300, 1'b0, 0);
    do_cmd(2'd0, 32'h000, 1'b1, 1);
    exp_mem(1'b0, 26'h10); do_cmd(2'd0, 32'h400, 1'b0, 0);
    exp_mem(1'b0, 26'h4);  do_cmd(2'd0, 32'h100, 1'b0, 0);
    do_cmd(2'd0, 32'h000, 1'b1, 1);
    check("t3_hit",  hit_cnt,  4);
    check("t3_miss", miss_cnt, 6);
    check("t3_read", read_cnt, 10);
    check("t3_wb",   wb_cnt,   0);

    // CLEAR: counters zeroed, sweep, then response
    do_cmd(2'd3, 32'h0, 1'b0, 0);
    check("clr_counters",
          {hit_cnt, miss_cnt, read_cnt, write_cnt, wb_cnt}, 0);

    // 4: dirty victim write-back
    exp_mem(1'b0, 26'h0);  do_cmd(2'd1, 32'h000, 1'b0, 0);
    exp_mem(1'b0, 26'h4);  do_cmd(2'd0, 32'h100, 1'b0, 0);
    exp_mem(1'b0, 26'h8);  do_cmd(2'd0, 32'h200, 1'b0, 0);
    exp_mem(1'b0, 26'hC);  do_cmd(2'd0, 32'h300, 1'b0, 0);
    exp_mem(1'b1, 26'h0);
    exp_mem(1'b0, 26'h10); do_cmd(2'd0, 32'h400, 1'b0, 0);
    check("t4_wb",    wb_cnt,    1);
    check("t4_write", write_cnt, 1);
    check("t4_read",  read_cnt,  4);
    check("t4_miss",  miss_cnt,  5);

    // 5: stalled fill, then reset mid-fill
    check("t5_idle", bus.req_ready, 1);
    bus.mem_ready = 1'b0;
    bus.req_cmd   = 2'd0;
    bus.req_addr  = 32'h040;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t5_mem_valid_%0d", i), bus.mem_valid, 1);
      check($sformatf("t5_mem_addr_%0d", i), bus.mem_addr, 26'h1);
      check($sformatf("t5_ready_%0d", i), bus.req_ready, 0);
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_mem_valid", bus.mem_valid, 0);
    check("t5_rst_miss", miss_cnt, 0);
    bus.mem_ready = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    sweep_wait();

    // 6: invalidate with write-back, absent invalidate
    exp_mem(1'b0, 26'h8);  do_cmd(2'd1, 32'h200, 1'b0, 0);
    exp_mem(1'b1, 26'h8);  do_cmd(2'd2, 32'h200, 1'b1, 0);
    exp_mem(1'b0, 26'h8);  do_cmd(2'd0, 32'h200, 1'b0, 0);
    do_cmd(2'd2, 32'h300, 1'b0, 0);
    check("t6_wb",    wb_cnt,    1);
    check("t6_miss",  miss_cnt,  2);
    check("t6_hit",   hit_cnt,   0);
    check("t6_write", write_cnt, 1);

    repeat (3) @(posedge clk);
    #1;
    check("rsp_q_empty", rsp_q.size(), 0);
    check("mem_q_empty", mem_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/assoc_cache_ctrl.md
Name: assoc_cache_ctrl

Overview:
Parametrised N-way set-associative data cache controller: tag/valid/dirty/age state only, no data array. Sits between the trace-driven CPU-side command stream and the next-level cache. Generalises the fixed 4-way model to configurable sets, ways and line size. Adds a write-back/write-allocate policy with dirty tracking, true-LRU age counters, valid/ready handshakes on both sides, and saturating statistics.

Parameters:
ADDR_W, 32, request address width
SETS, 16384, number of sets (power of 2, >=2)
WAYS, 4, associativity (power of 2, 2..16)
LINE_BYTES, 64, line size in bytes (power of 2)
CNT_W, 32, statistics counter width
Derived: OFF_W=log2(LINE_BYTES), IDX_W=log2(SETS), TAG_W=ADDR_W-IDX_W-OFF_W, AGE_W=log2(WAYS)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  CPU command valid
req_ready  out  1  controller can accept a command
req_cmd  in  2  0=READ 1=WRITE 2=INVALIDATE 3=CLEAR
req_addr  in  ADDR_W  byte address; tag=[ADDR_W-1:IDX_W+OFF_W], index=[IDX_W+OFF_W-1:OFF_W]
rsp_valid  out  1  one-cycle pulse: command complete
rsp_hit  out  1  qualified by rsp_valid; 1 = tag matched a valid way
mem_valid  out  1  next-level request valid
mem_ready  in  1  next-level accepts request
mem_we  out  1  1=write-back of dirty victim, 0=line fetch
mem_addr  out  ADDR_W-OFF_W  line address of mem request
hit_cnt, miss_cnt, read_cnt, write_cnt, wb_cnt  out  CNT_W each  statistics

Behaviour:
- Reset (rst_n low, async): all outputs 0, counters 0, FSM forced to SWEEP with sweep index 0; any in-flight mem request is dropped.
- States: SWEEP, IDLE, LOOKUP, WB, FILL, RESP.
- SWEEP: one set per cycle: valid=0, dirty=0, age[w]=w. Takes exactly SETS cycles, then IDLE. req_ready=0 throughout.
- IDLE: req_ready=1. A command is accepted on req_valid&&req_ready; cmd/addr are registered. Next state: LOOKUP, or SWEEP for CLEAR.
- CLEAR additionally zeroes all counters in the acceptance cycle. rsp_valid pulses once after the sweep completes, rsp_hit=0.
- LOOKUP (one cycle): compare tag against all valid ways; at most one match.
  - READ/WRITE hit: mark way MRU; WRITE sets dirty; hit_cnt++. Then RESP, rsp_hit=1. Latency: accept edge + 2 cycles to rsp_valid.
  - READ/WRITE miss: miss_cnt++. Victim = lowest-numbered invalid way, else the way with age==WAYS-1. Victim dirty -> WB, else FILL.
  - INVALIDATE hit on a dirty line -> WB, then clear valid/dirty. Clean hit: clear valid. Miss: no action. Go to RESP, rsp_hit reflects the match. Ages unchanged; counters unchanged.
  - read_cnt/write_cnt increment in LOOKUP for READ/WRITE regardless of outcome.
- WB: mem_valid=1, mem_we=1, mem_addr={victim tag, index}. Held stable until mem_ready; on handshake wb_cnt++. Then FILL, or RESP for INVALIDATE.
- FILL: mem_valid=1, mem_we=0, mem_addr=req_addr[ADDR_W-1:OFF_W]. Held until mem_ready. On handshake write tag, valid=1, dirty=(cmd==WRITE), mark way MRU, then RESP with rsp_hit=0.
- RESP: rsp_valid=1 for one cycle, then IDLE. req_ready=0 in every state except IDLE.
- MRU update, with old = age of accessed way: the way's age becomes 0, and every way with age < old increments. Ages remain a permutation of 0..WAYS-1 at all times. Fill into an invalid way uses the same rule.
- Counters saturate at all-ones and do not wrap.
- mem_valid is never deasserted before mem_ready once raised, except by reset.

Test Plan:
Bench config: SETS=4, WAYS=4, LINE_BYTES=64. Set 0 addresses are 0x000, 0x100, 0x200, 0x300, 0x400.
1. Release rst_n -> req_ready stays 0 for exactly 4 cycles, then 1. All counters read 0.
2. READ 0x000 -> FILL with mem_addr=0x0, rsp_hit=0. Second READ 0x000 -> rsp_valid 2 cycles after accept, rsp_hit=1, no mem request. Counters: hit=1, miss=1, read=2.
3. READ 0x000, 0x100, 0x200, 0x300, then READ 0x000 (hit), then READ 0x400 -> victim is way1 (tag 0x1). Subsequent READ 0x100 misses and READ 0x000 hits.
4. WRITE 0x000, then fill 0x100..0x400 -> the miss on 0x400 issues WB with mem_we=1, mem_addr=0x0, then FILL with mem_addr=0x10. wb_cnt=1.
5. Hold mem_ready=0 for 10 cycles during FILL -> mem_valid and mem_addr stable for all 10 cycles, req_ready=0. Assert rst_n=0 mid-FILL -> mem_valid drops immediately and the SWEEP restarts.
6. WRITE 0x200, then INVALIDATE 0x200 -> WB with mem_addr=0x8, rsp_hit=1. Then READ 0x200 misses. INVALIDATE 0x300 (absent) -> rsp_hit=0, no mem traffic.
